// File: rtl/inst_queue_pkg.sv
// Shared pipeline types for the fetch-to-decode instruction queue.
// Holds the fetch entry bundle and the default queue depth.
package inst_queue_pkg;

  localparam int IQ_DEPTH = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
  } fetch_entry_t;

endpackage

// File: rtl/inst_queue.sv
// Dual-issue instruction queue between ICache fetch and decode.
// INST_QUEUE_BYPASS_EN lets an empty queue forward the incoming beat.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic [63:0] in_data,
  input  logic        in_second_valid,
  input  logic        in_exc,
  output logic        in_ready,
  output logic [1:0]  out_valid,
  output logic [31:0] out_pc0,
  output logic [31:0] out_pc1,
  output logic [31:0] out_inst0,
  output logic [31:0] out_inst1,
  output logic [1:0]  out_exc,
  input  logic [1:0]  deq_num,
  input  logic        flush
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t mem_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  fetch_entry_t in0, in1;
  fetch_entry_t slot0, slot1;
  fetch_entry_t wr0, wr1;
  logic [1:0]   enq_n, req_n, avail_n, deq_n, wr_n;
  logic         byp;

  always_comb begin
    in0 = '{pc: in_pc, inst: in_data[31:0], exc: in_exc};
    in1 = '{pc: in_pc + 32'd4, inst: in_data[63:32], exc: in_exc};
    in_ready = (count_q <= CW'(DEPTH - 2));
    enq_n = 2'd0;
    if (in_valid && in_ready)
      enq_n = in_second_valid ? 2'd2 : 2'd1;
    req_n = deq_num[1] ? 2'd2 : deq_num;
`ifdef INST_QUEUE_BYPASS_EN
    byp = in_valid && (count_q == '0);
`else
    byp = 1'b0;
`endif
    avail_n = (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];
    if (byp)
      avail_n = enq_n;
    deq_n = (req_n < avail_n) ? req_n : avail_n;

    slot0     = mem_q[head_q];
    slot1     = mem_q[head_q + PW'(1)];
    out_valid = {count_q >= CW'(2), count_q != '0};
    wr0       = in0;
    wr1       = in1;
    wr_n      = enq_n;
    // Bypassed instructions that decode takes now never reach storage
    if (byp) begin
      slot0     = in0;
      slot1     = in1;
      out_valid = {in_second_valid, 1'b1};
      wr_n      = enq_n - deq_n;
      if (deq_n == 2'd1)
        wr0 = in1;
    end

    head_d  = byp ? head_q : head_q + PW'(deq_n);
    tail_d  = tail_q + PW'(wr_n);
    count_d = count_q + CW'(enq_n) - CW'(deq_n);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      wr_n    = 2'd0;
    end

    out_pc0   = slot0.pc;
    out_pc1   = slot1.pc;
    out_inst0 = slot0.inst;
    out_inst1 = slot1.inst;
    out_exc   = {slot1.exc, slot0.exc};
  end

  always_ff @(posedge clk) begin
    if (wr_n != 2'd0)
      mem_q[tail_q] <= wr0;
    if (wr_n == 2'd2)
      mem_q[tail_q + PW'(1)] <= wr1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Randomized bench for inst_queue against a queue-based reference model.
// Honours INST_QUEUE_BYPASS_EN when the design is built with it.
module tb_inst_queue;
  import inst_queue_pkg::*;

  localparam int DEPTH = IQ_DEPTH;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [63:0] in_data;
  logic        in_second_valid;
  logic        in_exc;
  logic        in_ready;
  logic [1:0]  out_valid;
  logic [31:0] out_pc0, out_pc1;
  logic [31:0] out_inst0, out_inst1;
  logic [1:0]  out_exc;
  logic [1:0]  deq_num;
  logic        flush;

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_pc(in_pc),
    .in_data(in_data),
    .in_second_valid(in_second_valid),
    .in_exc(in_exc), .in_ready(in_ready),
    .out_valid(out_valid),
    .out_pc0(out_pc0), .out_pc1(out_pc1),
    .out_inst0(out_inst0),
    .out_inst1(out_inst1),
    .out_exc(out_exc),
    .deq_num(deq_num), .flush(flush)
  );

  fetch_entry_t mq[$];
  logic [31:0]  seen[$];
  int errs = 0;
  int checks = 0;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    in_valid = 0;
    in_pc = '0;
    in_data = '0;
    in_second_valid = 0;
    in_exc = 0;
    deq_num = 2'd0;
    flush = 0;
  endtask

  // One cycle: drive, check outputs against the model, then advance it
  task automatic step(bit v, logic [31:0] pc, logic [63:0] d,
                      bit sv, bit ex, logic [1:0] dq, bit fl);
    fetch_entry_t inc[$];
    fetch_entry_t view[$];
    int n;
    bit acc;
    @(negedge clk);
    in_valid = v;
    in_pc = pc;
    in_data = d;
    in_second_valid = sv;
    in_exc = ex;
    deq_num = dq;
    flush = fl;
    #1;
    if (v) begin
      inc.push_back('{pc: pc, inst: d[31:0], exc: ex});
      if (sv)
        inc.push_back('{pc: pc + 32'd4, inst: d[63:32], exc: ex});
    end
    view = mq;
`ifdef INST_QUEUE_BYPASS_EN
    if (mq.size() == 0) view = inc;
`endif
    chk("in_ready", in_ready, mq.size() <= DEPTH - 2);
    chk("count", dut.count_q, mq.size());
    chk("out_valid", out_valid,
        {view.size() >= 2, view.size() >= 1});
    if (view.size() >= 1) begin
      chk("pc0", out_pc0, view[0].pc);
      chk("inst0", out_inst0, view[0].inst);
      chk("exc0", out_exc[0], view[0].exc);
    end
    if (view.size() >= 2) begin
      chk("pc1", out_pc1, view[1].pc);
      chk("inst1", out_inst1, view[1].inst);
      chk("exc1", out_exc[1], view[1].exc);
    end
    n = (dq == 2'd0) ? 0 : ((dq == 2'd1) ? 1 : 2);
    if (!fl) begin
      for (int i = 0; i < n && i < view.size(); i++)
        seen.push_back(i == 0 ? out_pc0 : out_pc1);
    end
    @(posedge clk);
    #1;
    if (fl) begin
      mq.delete();
    end else begin
      acc = v && (mq.size() <= DEPTH - 2);
`ifdef INST_QUEUE_BYPASS_EN
      if (acc && mq.size() == 0) begin
        mq = inc;
        acc = 0;
      end
`endif
      for (int i = 0; i < n && mq.size() > 0; i++)
        void'(mq.pop_front());
      if (acc)
        foreach (inc[i]) mq.push_back(inc[i]);
    end
    idle();
  endtask

  initial begin
    logic [31:0] pc;
    resetn = 0;
    idle();
    #12;
    chk("rst_valid", out_valid, 2'b00);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_count", dut.count_q, 0);
    @(negedge clk);
    resetn = 1;

    // first beat
    step(1, 32'hBFC00000, {32'h2, 32'h1}, 1, 0, 0, 0);
    chk("b_valid", out_valid, 2'b11);
    chk("b_pc0", out_pc0, 32'hBFC00000);
    chk("b_pc1", out_pc1, 32'hBFC00004);
    chk("b_inst0", out_inst0, 32'h1);
    chk("b_inst1", out_inst1, 32'h2);

    // fill to full, then overflow beat dropped
    step(0, 0, 0, 0, 0, 0, 1);
    pc = 32'h1000;
    for (int i = 0; i < 7; i++) begin
      step(1, pc, {$urandom, $urandom}, 1, 0, 0, 0);
      pc += 8;
    end
    chk("fill14_cnt", dut.count_q, 14);
    chk("fill14_rdy", in_ready, 1'b1);
    step(1, pc, {$urandom, $urandom}, 1, 0, 0, 0);
    pc += 8;
    chk("fill16_cnt", dut.count_q, 16);
    chk("fill16_rdy", in_ready, 1'b0);
    step(1, pc, {$urandom, $urandom}, 1, 1, 0, 0);
    chk("drop_cnt", dut.count_q, 16);

    // steady 2-in/2-out stream with pointer wrap
    step(0, 0, 0, 0, 0, 0, 1);
    seen.delete();
    pc = 32'h8000;
    for (int i = 0; i < 20; i++) begin
      step(1, pc, {$urandom, $urandom}, 1, 0, 2, 0);
      pc += 8;
    end
    step(0, 0, 0, 0, 0, 2, 0);
    step(0, 0, 0, 0, 0, 2, 0);
    chk("strm_n", seen.size(), 40);
    foreach (seen[i])
      chk("strm_pc", seen[i], 32'h8000 + 32'(i) * 4);
`ifdef INST_QUEUE_BYPASS_EN
    chk("strm_head", dut.head_q, 0);
`else
    chk("strm_head", dut.head_q, 8);
`endif

    // flush beats a simultaneous enqueue and dequeue
    step(1, 32'h40, {$urandom, $urandom}, 1, 0, 0, 0);
    step(1, 32'h48, {$urandom, $urandom}, 1, 0, 0, 0);
    step(1, 32'h50, {$urandom, $urandom}, 0, 0, 0, 0);
    chk("fl_cnt5", dut.count_q, 5);
    step(1, 32'h60, {$urandom, $urandom}, 1, 0, 1, 1);
    chk("fl_valid", out_valid, 2'b00);
    chk("fl_cnt", dut.count_q, 0);
    chk("fl_rdy", in_ready, 1'b1);

    // over-dequeue and single-instruction beat
    step(1, 32'h10, {$urandom, $urandom}, 0, 0, 0, 0);
    chk("one_cnt", dut.count_q, 1);
    step(0, 0, 0, 0, 0, 2, 0);
    chk("ovr_cnt", dut.count_q, 0);
    step(1, 32'h1C, {32'hDEAD, 32'h77}, 0, 0, 0, 0);
    chk("sgl_valid", out_valid, 2'b01);
    chk("sgl_pc0", out_pc0, 32'h1C);
    chk("sgl_cnt", dut.count_q, 1);

`ifdef INST_QUEUE_BYPASS_EN
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 32'h200, {32'hB, 32'hA}, 1, 0, 2, 0);
    chk("byp_cnt", dut.count_q, 0);
`endif

    // random traffic with a mid-run asynchronous reset
    pc = 32'h4000;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        @(negedge clk);
        #2 resetn = 0;
        #1;
        chk("mid_rst_valid", out_valid, 2'b00);
        chk("mid_rst_ready", in_ready, 1'b1);
        mq.delete();
        @(negedge clk);
        resetn = 1;
      end
      step($urandom_range(0, 3) != 0, pc,
           {$urandom, $urandom}, 1'($urandom),
           1'($urandom), 2'($urandom),
           $urandom_range(0, 19) == 0);
      pc += 8;
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
